// File: rtl/mseq_sched_if.sv
// Bus between mseq_sched, its burst requesters / config master and the shared mfun LFSR step.
interface mseq_sched_if #(
  parameter int WIDTH = 5
);
  logic [1:0]       req;
  logic             cfg_we;
  logic             cfg_ch;
  logic [WIDTH-1:0] cfg_fase;
  logic [WIDTH-1:0] cfg_type;
  logic [WIDTH-1:0] mf_fase;
  logic [WIDTH-1:0] mf_type;
  logic [WIDTH-1:0] mf_fase_new;
  logic             mf_sum;
  logic             chip;
  logic [1:0]       chip_valid;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0]       err;
  logic [1:0]       short_period;

  modport master (
    output req, cfg_we, cfg_ch, cfg_fase, cfg_type, mf_fase_new, mf_sum,
    input  mf_fase, mf_type, chip, chip_valid, busy, done, err, short_period
  );

  modport slave (
    input  req, cfg_we, cfg_ch, cfg_fase, cfg_type, mf_fase_new, mf_sum,
    output mf_fase, mf_type, chip, chip_valid, busy, done, err, short_period
  );
endinterface

// File: rtl/mseq_sched.sv
// Two-channel round-robin scheduler time-sharing one mfun LFSR step between burst requesters.
// Optional short-period detection is enabled by defining MSEQ_PERIOD_CHECK_EN.
module mseq_sched #(
  parameter int               WIDTH     = 5,
  parameter int               FRAME_LEN = 31,
  parameter logic [WIDTH-1:0] SEED_RST  = 5'b10101,
  parameter logic [WIDTH-1:0] POLY_RST  = 5'b11101
) (
  input logic         clk,
  input logic         rst,
  mseq_sched_if.slave bus
);
  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(FRAME_LEN - 1);

  logic [WIDTH-1:0] seed_q  [2];
  logic [WIDTH-1:0] poly_q  [2];
  logic [WIDTH-1:0] state_q [2];
  logic [WIDTH-1:0] cnt_q   [2];
  logic [1:0]       busy_q;
  logic [1:0]       chip_valid_q;
  logic [1:0]       done_q;
  logic [1:0]       err_q;
  logic             chip_q;
  logic             last_q;

  logic             gnt;
  logic             gnt_valid;
  logic             gnt_last;
  logic             cfg_ok;
  logic [1:0]       start;
  logic [1:0]       reject;
  logic [1:0]       cfg_err;
  logic [WIDTH-1:0] eff_seed [2];

  // Only channels already busy compete; a channel starting this cycle waits one cycle.
  always_comb begin
    gnt = 1'b0;
    if (busy_q == 2'b11) begin
      gnt = ~last_q;
    end else if (busy_q == 2'b10) begin
      gnt = 1'b1;
    end
  end

  assign gnt_valid = |busy_q;
  assign gnt_last  = (cnt_q[gnt] == LAST_CNT);
  assign cfg_ok    = bus.cfg_we && !busy_q[bus.cfg_ch];

  // A same-cycle config write supplies the seed used by a starting burst.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eff_seed[i] = (cfg_ok && (bus.cfg_ch == 1'(i))) ? bus.cfg_fase : seed_q[i];
      cfg_err[i]  = bus.cfg_we && (bus.cfg_ch == 1'(i)) && busy_q[i];
      start[i]    = bus.req[i] && !busy_q[i] && (eff_seed[i] != '0);
      reject[i]   = bus.req[i] && !busy_q[i] && (eff_seed[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        seed_q[i]  <= SEED_RST;
        poly_q[i]  <= POLY_RST;
        state_q[i] <= SEED_RST;
        cnt_q[i]   <= '0;
      end
      busy_q       <= '0;
      chip_valid_q <= '0;
      done_q       <= '0;
      err_q        <= '0;
      chip_q       <= 1'b0;
      last_q       <= 1'b1;
    end else begin
      chip_valid_q <= '0;
      done_q       <= '0;
      err_q        <= cfg_err | reject;
      for (int i = 0; i < 2; i++) begin
        if (cfg_ok && (bus.cfg_ch == 1'(i))) begin
          seed_q[i] <= bus.cfg_fase;
          poly_q[i] <= bus.cfg_type;
        end
        if (start[i]) begin
          busy_q[i]  <= 1'b1;
          state_q[i] <= eff_seed[i];
          cnt_q[i]   <= '0;
        end
      end
      if (gnt_valid) begin
        last_q            <= gnt;
        chip_q            <= bus.mf_sum;
        chip_valid_q[gnt] <= 1'b1;
        if (gnt_last) begin
          done_q[gnt]  <= 1'b1;
          busy_q[gnt]  <= 1'b0;
          state_q[gnt] <= seed_q[gnt];
          cnt_q[gnt]   <= '0;
        end else begin
          state_q[gnt] <= bus.mf_fase_new;
          cnt_q[gnt]   <= cnt_q[gnt] + WIDTH'(1);
        end
      end
    end
  end

  assign bus.mf_fase    = state_q[gnt];
  assign bus.mf_type    = poly_q[gnt];
  assign bus.chip       = chip_q;
  assign bus.chip_valid = chip_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

`ifdef MSEQ_PERIOD_CHECK_EN
  logic [1:0] short_q;

  // Returning to the seed before the last chip means the polynomial is not maximal-length.
  always_ff @(posedge clk) begin
    if (rst) begin
      short_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start[i]) begin
          short_q[i] <= 1'b0;
        end
      end
      if (gnt_valid && !gnt_last && (bus.mf_fase_new == seed_q[gnt])) begin
        short_q[gnt] <= 1'b1;
      end
    end
  end

  assign bus.short_period = short_q;
`else
  assign bus.short_period = 2'b00;
`endif
endmodule

// File: tb/tb_mseq_sched.sv
// Self-checking bench for mseq_sched: stimulus table plus hand sequences, chips checked
// against a per-channel scoreboard filled from an LFSR reference model.
module tb_mseq_sched;
  localparam int           W        = 5;
  localparam int           FL       = 31;
  localparam logic [W-1:0] SEED_RST = 5'b10101;
  localparam logic [W-1:0] POLY_RST = 5'b11101;
  localparam int           NV       = 96;
`ifdef MSEQ_PERIOD_CHECK_EN
  localparam logic         EXP_SP   = 1'b1;
`else
  localparam logic         EXP_SP   = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]   req;
    logic         cfg_we;
    logic         cfg_ch;
    logic [W-1:0] cfg_fase;
    logic [W-1:0] cfg_type;
    logic         push;
    logic [W-1:0] pseed;
    logic [W-1:0] ppoly;
    logic [1:0]   exp_busy;
    logic [1:0]   exp_err;
  } vec_t;

  typedef struct packed {
    logic chip;
    logic last;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  bit   mon_en;
  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl [NV];

  mseq_sched_if #(.WIDTH(W)) bus ();

  mseq_sched #(
    .WIDTH(W), .FRAME_LEN(FL), .SEED_RST(SEED_RST), .POLY_RST(POLY_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Reference mfun: Fibonacci LFSR, chip is the MSB, feedback is the parity of tapped bits.
  function automatic logic [W:0] mfun(input logic [W-1:0] fase, input logic [W-1:0] poly);
    return {fase[W-1], fase[W-2:0], ^(fase & poly)};
  endfunction

  assign {bus.mf_sum, bus.mf_fase_new} = mfun(bus.mf_fase, bus.mf_type);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic pushBurst(input int ch, input logic [W-1:0] seed, input logic [W-1:0] poly);
    logic [W-1:0] s;
    exp_t e;
    s = seed;
    for (int k = 0; k < FL; k++) begin
      e.chip = s[W-1];
      e.last = (k == FL - 1);
      s = {s[W-2:0], ^(s & poly)};
      if (ch == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Per-cycle monitor: pops the owning channel's scoreboard on every chip_valid.
  task automatic checkOutput();
    exp_t e;
    bit   empty;
    if (mon_en) begin
      check("cv_onehot", 32'($countones(bus.chip_valid) <= 1), 32'd1);
      check("done_without_cv", 32'(bus.done & ~bus.chip_valid), 32'd0);
      for (int ch = 0; ch < 2; ch++) begin
        if (bus.chip_valid[ch]) begin
          empty = (ch == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL unexpected_chip ch%0d: got chip_valid, expected none", ch);
          end else begin
            e = (ch == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("chip_ch%0d", ch), 32'(bus.chip), 32'(e.chip));
            check($sformatf("done_ch%0d", ch), 32'(bus.done[ch]), 32'(e.last));
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic setIdle();
    bus.req      = 2'b00;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = 1'b0;
    bus.cfg_fase = '0;
    bus.cfg_type = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.req      = v.req;
    bus.cfg_we   = v.cfg_we;
    bus.cfg_ch   = v.cfg_ch;
    bus.cfg_fase = v.cfg_fase;
    bus.cfg_type = v.cfg_type;
    if (v.push) pushBurst(0, v.pseed, v.ppoly);
    tick();
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_chip"}, 32'(bus.chip), 32'd0);
    check({tag, "_cv"}, 32'(bus.chip_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_sp"}, 32'(bus.short_period), 32'd0);
    check({tag, "_mf_fase"}, 32'(bus.mf_fase), 32'(SEED_RST));
    check({tag, "_mf_type"}, 32'(bus.mf_type), 32'(POLY_RST));
  endtask

  task automatic doReset();
    setIdle();
    rst = 1'b1;
    tick();
    q0.delete();
    q1.delete();
    mon_en = 1'b1;
    tick();
    checkReset("reset");
    rst = 1'b0;
  endtask

  task automatic waitDone(input int ch, input int budget, output int ticks);
    bit seen;
    seen  = 1'b0;
    ticks = 0;
    while (!seen && ticks < budget) begin
      tick();
      ticks++;
      if (bus.done[ch]) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL done_timeout ch%0d: no done after %0d cycles, expected one", ch, budget);
    end
  endtask

  task automatic checkDrained(input string tag);
    check({tag, "_q0_left"}, 32'(q0.size()), 32'd0);
    check({tag, "_q1_left"}, 32'(q1.size()), 32'd0);
  endtask

  int ticks;
  int chips;
  bit seen;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    setIdle();

    // Single burst on ch0: latency, length and chip values.
    doReset();
    pushBurst(0, SEED_RST, POLY_RST);
    bus.req = 2'b01;
    tick();
    bus.req = 2'b00;
    check("t2_busy_after_start", 32'(bus.busy), 32'd1);
    check("t2_no_cv_yet", 32'(bus.chip_valid), 32'd0);
    tick();
    check("t2_first_cv", 32'(bus.chip_valid), 32'd1);
    ticks = 1;
    chips = 1;
    seen  = bus.done[0];
    while (!seen && ticks < 40) begin
      tick();
      ticks++;
      if (bus.chip_valid[0]) chips++;
      seen = bus.done[0];
    end
    check("t2_burst_cycles", 32'(ticks), 32'(FL));
    check("t2_chip_count", 32'(chips), 32'(FL));
    check("t2_short_period", 32'(bus.short_period), 32'd0);
    tick();
    check("t2_idle_after", 32'(bus.busy), 32'd0);
    checkDrained("t2");

    // Both channels from reset: strict alternation, ch0 restarts after one idle cycle.
    doReset();
    bus.cfg_we = 1'b1; bus.cfg_ch = 1'b1; bus.cfg_fase = 5'b00111; bus.cfg_type = 5'b11101;
    tick();
    setIdle();
    check("t3_cfg_ok_err", 32'(bus.err), 32'd0);
    pushBurst(0, SEED_RST, POLY_RST);
    pushBurst(1, 5'b00111, 5'b11101);
    bus.req = 2'b11;
    tick();
    check("t3_both_busy", 32'(bus.busy), 32'd3);
    for (int k = 1; k <= 62; k++) begin
      tick();
      check($sformatf("t3_cv_%0d", k), 32'(bus.chip_valid), (k % 2 == 1) ? 32'd1 : 32'd2);
      check($sformatf("t3_done_%0d", k), 32'(bus.done),
            (k == 61) ? 32'd1 : ((k == 62) ? 32'd2 : 32'd0));
      if (k == 61) pushBurst(0, SEED_RST, POLY_RST);
      if (k == 62) begin
        check("t3_restart_busy", 32'(bus.busy), 32'd1);
        bus.req = 2'b00;
      end
    end
    tick();
    check("t3_restart_cv", 32'(bus.chip_valid), 32'd1);
    waitDone(0, 40, ticks);
    checkDrained("t3");

    // Table: rejected write while busy, reuse of old seed, same-cycle write+start, zero seed.
    for (int r = 0; r < NV; r++) begin
      tbl[r] = '0;
      tbl[r].exp_busy = 2'b01;
    end
    tbl[0].req = 2'b01; tbl[0].push = 1'b1; tbl[0].pseed = SEED_RST; tbl[0].ppoly = POLY_RST;
    tbl[1].cfg_we = 1'b1; tbl[1].cfg_fase = 5'b01001; tbl[1].cfg_type = 5'b00011;
    tbl[1].exp_err = 2'b01;
    tbl[31].exp_busy = 2'b00;
    tbl[32].req = 2'b01; tbl[32].push = 1'b1; tbl[32].pseed = SEED_RST; tbl[32].ppoly = POLY_RST;
    tbl[63].exp_busy = 2'b00;
    tbl[64].req = 2'b01; tbl[64].cfg_we = 1'b1; tbl[64].cfg_fase = 5'b00110;
    tbl[64].cfg_type = 5'b11101; tbl[64].push = 1'b1; tbl[64].pseed = 5'b00110;
    tbl[64].ppoly = 5'b11101;
    tbl[65].cfg_we = 1'b1; tbl[65].cfg_ch = 1'b1; tbl[65].cfg_fase = 5'b00000;
    tbl[65].cfg_type = 5'b11101;
    tbl[66].req = 2'b10; tbl[66].exp_err = 2'b10;
    tbl[67].req = 2'b10; tbl[67].exp_err = 2'b10;
    tbl[95].exp_busy = 2'b00;
    doReset();
    for (int r = 0; r < NV; r++) begin
      applyStimulus(tbl[r]);
      check($sformatf("tbl%0d_busy", r), 32'(bus.busy), 32'(tbl[r].exp_busy));
      check($sformatf("tbl%0d_err", r), 32'(bus.err), 32'(tbl[r].exp_err));
    end
    setIdle();
    checkDrained("tbl");

    // Short-period detection with a non-maximal polynomial (seed lies on a 3-state cycle).
    doReset();
    pushBurst(0, 5'b01101, 5'b00011);
    bus.req = 2'b01; bus.cfg_we = 1'b1; bus.cfg_fase = 5'b01101; bus.cfg_type = 5'b00011;
    tick();
    setIdle();
    check("t5_sp_at_start", 32'(bus.short_period), 32'd0);
    waitDone(0, 40, ticks);
    check("t5_sp_at_done", 32'(bus.short_period), 32'({1'b0, EXP_SP}));
    checkDrained("t5");

    // Reset mid-burst discards state and config; restart uses the reset seed.
    doReset();
    pushBurst(0, 5'b01110, 5'b11101);
    bus.req = 2'b01; bus.cfg_we = 1'b1; bus.cfg_fase = 5'b01110; bus.cfg_type = 5'b11101;
    tick();
    setIdle();
    chips = 0;
    ticks = 0;
    while (chips < 10 && ticks < 20) begin
      tick();
      ticks++;
      if (bus.chip_valid[0]) chips++;
    end
    check("t6_chips_before_rst", 32'(chips), 32'd10);
    rst = 1'b1;
    tick();
    checkReset("t6_midrst");
    q0.delete();
    rst = 1'b0;
    pushBurst(0, SEED_RST, POLY_RST);
    bus.req = 2'b01;
    tick();
    bus.req = 2'b00;
    check("t6_restart_busy", 32'(bus.busy), 32'd1);
    waitDone(0, 40, ticks);
    check("t6_restart_cycles", 32'(ticks), 32'(FL));
    checkDrained("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
